dual_issue_ctrl: RTL

- Issue scheduler between the dual-slot fetch stage and dual decode.
- Buffers fetched instruction pairs in a small circular queue and drives the fetch enables (en1/en2) as back-pressure.
- Each cycle, decides whether the head pair can issue together or only the oldest instruction issues.
- Flushes the queue on an execute-stage redirect.

---
 rtl/issue_pkg.sv | 31 +++
 rtl/pair_hazard_check.sv | 77 +++++++
 rtl/dual_issue_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : issue_pkg
// Purpose  : Shared definitions for the dual-issue scheduler: the RV32I
//            opcodes the pairing rules depend on, the canonical NOP, and the
//            queue entry layout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package issue_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } q_entry_t;

endpackage
`default_nettype wire

// File: rtl/pair_hazard_check.sv
`default_nettype none
// ============================================================================
// Module   : pair_hazard_check
// Purpose  : Decides whether two adjacent instructions may issue in the same
//            cycle. Purely combinational.
// Ports    : instr_old   in  32  older (head) instruction
//            instr_young in  32  younger instruction
//            pair_ok     out 1   1 = both may issue together
// Revision : 1.0 - initial release
// ============================================================================
module pair_hazard_check (
  input  logic [31:0] instr_old,
  input  logic [31:0] instr_young,
  output logic        pair_ok
);
  import issue_pkg::*;

  logic [6:0] w_op_old;
  logic [6:0] w_op_yng;
  logic [4:0] w_rd_old;
  logic [4:0] w_rs1_yng;
  logic [4:0] w_rs2_yng;
  logic       w_old_writes_rd;
  logic       w_yng_reads_rs1;
  logic       w_yng_reads_rs2;
  logic       w_old_is_ctrl;
  logic       w_old_is_mem;
  logic       w_yng_is_mem;
  logic       w_raw;

  // funct3/funct7 and the old instruction's source fields do not affect pairing
  logic w_unused_bits;
  assign w_unused_bits = ^{instr_old[31:12], instr_young[31:25], instr_young[14:7]};

  assign w_op_old  = instr_old[6:0];
  assign w_op_yng  = instr_young[6:0];
  assign w_rd_old  = instr_old[11:7];
  assign w_rs1_yng = instr_young[19:15];
  assign w_rs2_yng = instr_young[24:20];

  always_comb begin
    w_old_writes_rd = 1'b0;
    case (w_op_old)
      OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR: w_old_writes_rd = 1'b1;
      default:                                 w_old_writes_rd = 1'b0;
    endcase
  end

  // Unknown opcodes are treated as rs1 readers (conservative)
  always_comb begin
    w_yng_reads_rs1 = 1'b1;
    case (w_op_yng)
      LUI, AUIPC, JAL: w_yng_reads_rs1 = 1'b0;
      default:         w_yng_reads_rs1 = 1'b1;
    endcase
  end

  always_comb begin
    w_yng_reads_rs2 = 1'b0;
    case (w_op_yng)
      OP, STORE, BRANCH: w_yng_reads_rs2 = 1'b1;
      default:           w_yng_reads_rs2 = 1'b0;
    endcase
  end

  assign w_old_is_ctrl = (w_op_old == BRANCH) || (w_op_old == JAL) || (w_op_old == JALR);
  assign w_old_is_mem  = (w_op_old == LOAD) || (w_op_old == STORE);
  assign w_yng_is_mem  = (w_op_yng == LOAD) || (w_op_yng == STORE);

  assign w_raw = w_old_writes_rd && (w_rd_old != 5'd0) &&
                 ((w_yng_reads_rs1 && (w_rs1_yng == w_rd_old)) ||
                  (w_yng_reads_rs2 && (w_rs2_yng == w_rd_old)));

  assign pair_ok = !w_raw && !w_old_is_ctrl && !(w_old_is_mem && w_yng_is_mem);

endmodule
`default_nettype wire

// File: rtl/dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl
// Purpose  : Issue scheduler between dual-slot fetch and dual decode. Buffers
//            fetched pairs in a circular queue, back-pressures fetch and
//            issues one or two head instructions per cycle. Flushed by an
//            execute-stage redirect.
// Config   : `define DUAL_ISSUE_EN enables slot-2 issue and the pair hazard
//            checker; without it the block issues at most one per cycle.
// Ports    : clk, rst (async, active high)
//            FlushE, FetchValidF, InstrF1/2, PCF1/2, StallD  inputs
//            en1, en2                  fetch PC enables
//            IssueValid1/2, InstrD1/2, PCD1/2   issue slots
//            CountQ                    queue occupancy
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     FlushE,
  input  logic                     FetchValidF,
  input  logic [31:0]              InstrF1,
  input  logic [31:0]              InstrF2,
  input  logic [31:0]              PCF1,
  input  logic [31:0]              PCF2,
  input  logic                     StallD,
  output logic                     en1,
  output logic                     en2,
  output logic                     IssueValid1,
  output logic                     IssueValid2,
  output logic [31:0]              InstrD1,
  output logic [31:0]              InstrD2,
  output logic [31:0]              PCD1,
  output logic [31:0]              PCD2,
  output logic [$clog2(DEPTH):0]   CountQ
);
  import issue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  q_entry_t        r_queue [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic [CW-1:0]   w_space;
  logic            w_en;
  logic            w_push;
  logic [1:0]      w_pop;
  logic [CW-1:0]   w_count_next;
  logic [PW-1:0]   w_wr_ptr1;
  q_entry_t        w_head1;

  // Back-pressure uses registered occupancy only; a pop in this cycle is
  // not credited, so fetch may stall one cycle longer than strictly needed.
  assign w_space = CW'(DEPTH) - r_count;
  assign w_en    = (w_space >= CW'(2));
  assign en1     = w_en;
  assign en2     = w_en;

  assign w_push    = FetchValidF && w_en && !FlushE;
  assign w_wr_ptr1 = r_wr_ptr + PW'(1);
  assign w_head1   = r_queue[r_rd_ptr];

  assign IssueValid1 = (r_count != '0) && !FlushE && !StallD;
  assign InstrD1     = IssueValid1 ? w_head1.instr : NOP_INSTR;
  assign PCD1        = IssueValid1 ? w_head1.pc    : 32'd0;

`ifdef DUAL_ISSUE_EN
  logic [PW-1:0] w_rd_ptr1;
  q_entry_t      w_head2;
  logic          w_pair_ok;

  assign w_rd_ptr1 = r_rd_ptr + PW'(1);
  assign w_head2   = r_queue[w_rd_ptr1];

  pair_hazard_check u_pair_hazard_check (
    .instr_old   (w_head1.instr),
    .instr_young (w_head2.instr),
    .pair_ok     (w_pair_ok)
  );

  assign IssueValid2 = IssueValid1 && (r_count >= CW'(2)) && w_pair_ok;
  assign InstrD2     = IssueValid2 ? w_head2.instr : NOP_INSTR;
  assign PCD2        = IssueValid2 ? w_head2.pc    : 32'd0;
`else
  assign IssueValid2 = 1'b0;
  assign InstrD2     = NOP_INSTR;
  assign PCD2        = 32'd0;
`endif

  assign w_pop        = {1'b0, IssueValid1} + {1'b0, IssueValid2};
  assign w_count_next = r_count + (w_push ? CW'(2) : CW'(0)) - CW'(w_pop);
  assign CountQ       = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_queue[i] <= '0;
      end
    end else if (FlushE) begin
      // Redirect: drop everything, including this cycle's fetch pair
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_queue[r_wr_ptr]  <= '{instr: InstrF1, pc: PCF1};
        r_queue[w_wr_ptr1] <= '{instr: InstrF2, pc: PCF2};
        r_wr_ptr           <= r_wr_ptr + PW'(2);
      end
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_count_next;
    end
  end

endmodule
`default_nettype wire
